// File: rtl/ahblite_dmac_mc_if.sv
// AHB-Lite slave port bundle for the multi-channel DMA front end.
// Master side is the system bus, slave side is the DMA controller.
interface ahblite_dmac_mc_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HPROT,
    output HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HPROT,
    input  HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/ahblite_dmac_mc.sv
// Multi-channel AHB-Lite DMA front end: descriptor bank, round-robin
// scheduler and engine sequencer. Optional interrupt: `DMAC_IRQ_EN.
module ahblite_dmac_mc #(
  parameter int NCH   = 4,
  parameter int LEN_W = 32
) (
  input  logic             HCLK,
  input  logic             HRESET,
  ahblite_dmac_mc_if.slave ahb,
  input  logic             HMASTERC,
  input  logic             DMAdone,
  input  logic             SLEEPing,
  output logic             DMAstart,
  output logic [31:0]      DMAsrc,
  output logic [31:0]      DMAdst,
  output logic [1:0]       DMAsize,
  output logic [LEN_W-1:0] DMAlen,
  output logic             HMASTERSEL,
  output logic             IRQ
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_SLEEP = 2'd1;
  localparam logic [1:0] TRANS      = 2'd2;
  localparam logic [1:0] WAIT_WAKE  = 2'd3;

  localparam logic [6:0] STAT_A = 7'h40;
  localparam logic [6:0] INT_A  = 7'h41;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [31:0]      src_r  [NCH];
  logic [31:0]      dst_r  [NCH];
  logic [1:0]       size_r [NCH];
  logic [LEN_W-1:0] len_r  [NCH];

  logic [NCH-1:0] pend, intstat, ch_oh, gr_oh;
  logic [NCH-1:0] set_p, clr_p;
  logic [2:0]     grant, last_grant, nxt, ch;
  logic [CW-1:0]  ci, gi;
  logic [1:0]     state, rsel;
  logic [3:0]     cand;
  logic [7:0]     pend8;
  logic           found, done;
  logic           ap_v, ap_w, wr, ch_hit, wr_ok;
  logic [6:0]     ap_a;
  logic [31:0]    rdata;
  logic           unused_ok;

  assign unused_ok = ^{ahb.HSIZE, ahb.HPROT,
                       ahb.HADDR[31:9], ahb.HADDR[1:0]};

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ap_v <= 1'b0;
      ap_w <= 1'b0;
      ap_a <= '0;
    end else begin
      ap_v <= ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
      ap_w <= ahb.HWRITE;
      ap_a <= ahb.HADDR[8:2];
    end
  end

  assign ch     = ap_a[4:2];
  assign rsel   = ap_a[1:0];
  assign ci     = ch[CW-1:0];
  assign gi     = grant[CW-1:0];
  assign ch_hit = (ap_a[6:5] == 2'b00) && (32'(ch) < NCH);
  assign wr     = ap_v & ap_w;
  // The granted descriptor is frozen until the sequencer is back in IDLE
  assign wr_ok  = wr & ch_hit &
                  ~((state != IDLE) & (ch == grant));
  assign done   = (state == TRANS) & DMAdone;
  assign ch_oh  = NCH'(1) << ch;
  assign gr_oh  = NCH'(1) << grant;
  assign set_p  = (wr_ok && rsel == 2'd3 &&
                   |ahb.HWDATA[LEN_W-1:0]) ? ch_oh : '0;
  assign clr_p  = done ? gr_oh : '0;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < NCH; i++) begin
        src_r[i]  <= '0;
        dst_r[i]  <= '0;
        size_r[i] <= '0;
        len_r[i]  <= '0;
      end
      pend <= '0;
    end else begin
      if (wr_ok) begin
        unique case (1'b1)
          rsel == 2'd0: src_r[ci]  <= ahb.HWDATA;
          rsel == 2'd1: dst_r[ci]  <= ahb.HWDATA;
          rsel == 2'd2: size_r[ci] <= ahb.HWDATA[1:0];
          rsel == 2'd3: len_r[ci]  <= ahb.HWDATA[LEN_W-1:0];
        endcase
      end
      pend <= (pend | set_p) & ~clr_p;
    end
  end

  assign pend8 = 8'(pend);

  // Round-robin: first pending channel after last_grant, wrapping
  always_comb begin
    nxt   = last_grant;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = {1'b0, last_grant} + 4'(i);
      if (cand >= 4'(NCH))
        cand = cand - 4'(NCH);
      if (!found && pend8[cand[2:0]]) begin
        nxt   = cand[2:0];
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= 3'(NCH - 1);
    end else begin
      unique case (state)
        IDLE: if (found) begin
          grant      <= nxt;
          last_grant <= nxt;
          state      <= WAIT_SLEEP;
        end
        WAIT_SLEEP: if (SLEEPing) state <= TRANS;
        TRANS:      if (DMAdone)  state <= WAIT_WAKE;
        WAIT_WAKE:  if (!SLEEPing) state <= IDLE;
      endcase
    end
  end

`ifdef DMAC_IRQ_EN
  logic [NCH-1:0] w1c;
  assign w1c = (wr && ap_a == INT_A) ?
               ahb.HWDATA[NCH-1:0] : '0;
  always_ff @(posedge HCLK) begin
    if (HRESET) intstat <= '0;
    else        intstat <= (intstat & ~w1c) | clr_p;
  end
  assign IRQ = |intstat;
`else
  assign intstat = '0;
  assign IRQ     = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (ap_v && !ap_w) begin
      if (ch_hit) begin
        case (rsel)
          2'd0: rdata = src_r[ci];
          2'd1: rdata = dst_r[ci];
          2'd2: rdata = 32'(size_r[ci]);
          default: rdata = 32'(len_r[ci]);
        endcase
      end else if (ap_a == STAT_A) begin
        rdata = {18'b0, state, 1'b0, grant, pend8};
      end else if (ap_a == INT_A) begin
        rdata = 32'(intstat);
      end
    end
  end

  assign ahb.HRDATA    = rdata;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;

  assign DMAstart   = (state == WAIT_SLEEP) & SLEEPing;
  assign DMAsrc     = src_r[gi];
  assign DMAdst     = dst_r[gi];
  assign DMAsize    = size_r[gi];
  assign DMAlen     = len_r[gi];
  assign HMASTERSEL = ~((state == TRANS) & HMASTERC);

endmodule
